// File: rtl/flash_read_if.sv
// ---------------------------------------------------------------------------
// flash_read_if
//   Pipelined flash read bus between a reader (master) and the flash
//   responder (slave).
//
//   flsh_address        master -> slave   word address
//   flsh_read           master -> slave   read request, held until accepted
//   flsh_byteenable     master -> slave   byte lanes to return
//   flsh_waitrequest    slave  -> master  1 = request not accepted this cycle
//   flsh_readdata       slave  -> master  returned word
//   flsh_readdatavalid  slave  -> master  1-cycle pulse, readdata valid
// ---------------------------------------------------------------------------
interface flash_read_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   flsh_address;
    logic                flsh_read;
    logic [DATA_W/8-1:0] flsh_byteenable;
    logic                flsh_waitrequest;
    logic [DATA_W-1:0]   flsh_readdata;
    logic                flsh_readdatavalid;

    modport master (
        output flsh_address, flsh_read, flsh_byteenable,
        input  flsh_waitrequest, flsh_readdata, flsh_readdatavalid
    );

    modport slave (
        input  flsh_address, flsh_read, flsh_byteenable,
        output flsh_waitrequest, flsh_readdata, flsh_readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// ---------------------------------------------------------------------------
// flash_read_responder
//   Slave-side stand-in for the music-player flash. Accepts pipelined word
//   reads after WAIT_CYCLES stall cycles, caps outstanding reads at
//   MAX_PENDING, fetches from a synchronous 1-cycle backing memory and
//   returns each word exactly READ_LATENCY cycles after its accept, in order.
//
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   flsh           flash read bus (slave side)
//   mem_address    backing-memory word address
//   mem_read       backing-memory read strobe
//   mem_rdata      backing-memory data, valid 1 cycle after mem_read
//   range_err      pulses with readdatavalid for an out-of-range read
//   reads_served   completed-read counter, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module flash_read_responder #(
    parameter int                ADDR_W       = 23,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDRESS  = 23'h7FFFF,
    parameter int                WAIT_CYCLES  = 2,
    parameter int                READ_LATENCY = 3,
    parameter int                MAX_PENDING  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    flash_read_if.slave        flsh,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_read,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               range_err,
    output logic [15:0]        reads_served
);
    localparam int BE_W = DATA_W / 8;
    localparam int L    = READ_LATENCY;

    localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);
    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

    // Request phase, decoded from the current request and counters.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    logic [1:0]        state;
    logic [3:0]        wcnt;
    logic [3:0]        pending;
    logic              wait_done;
    logic              room;
    logic              accept;
    logic              oor;
    logic              rdv;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] out_word;

    // Per-read control pipeline: stage k is the read accepted k+1 cycles ago.
    logic [L-1:0]      c_valid;
    logic [L-1:0]      c_oor;
    logic [BE_W-1:0]   c_be [L];

    // ---------------------------------------------------------------------
    // Accept logic
    // ---------------------------------------------------------------------
    assign wait_done = (wcnt == WAIT_MAX);
    // A slot retiring this cycle can be refilled in the same cycle, so the
    // counter stays within 0..MAX_PENDING while a full pipe keeps streaming.
    assign room      = (pending < PEND_MAX) || rdv;
    // Gating with rst_n keeps waitrequest high during reset even when no
    // stall cycles are configured.
    assign accept    = rst_n && flsh.flsh_read && wait_done && room;
    assign oor       = (flsh.flsh_address > MAX_ADDRESS);

    assign flsh.flsh_waitrequest = !accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state = ST_IDLE;
        if (flsh.flsh_read) begin
            state = accept ? ST_GRANT : ST_STALL;
        end
    end

    // Wait counter: counts stall cycles of the current held request and
    // restarts whenever the request is granted or withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments; combinational blocks use blocking.
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else begin
            case (state)
                ST_STALL: if (!wait_done) wcnt <= wcnt + 4'd1;
                default:  wcnt <= 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 4'd0;
        end else if (accept && !rdv) begin
            pending <= pending + 4'd1;
        end else if (!accept && rdv) begin
            pending <= pending - 4'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Backing-memory request
    // ---------------------------------------------------------------------
    assign mem_read    = accept && !oor;
    assign mem_address = accept ? flsh.flsh_address : mem_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
        end else if (accept) begin
            mem_addr_q <= flsh.flsh_address;
        end
    end

    // ---------------------------------------------------------------------
    // Control pipeline {valid, byteenable, oor}
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= '0;
            c_oor   <= '0;
            for (int k = 0; k < L; k++) c_be[k] <= '0;
        end else begin
            c_valid[0] <= accept;
            c_oor[0]   <= oor;
            c_be[0]    <= flsh.flsh_byteenable;
            for (int k = 1; k < L; k++) begin
                c_valid[k] <= c_valid[k-1];
                c_oor[k]   <= c_oor[k-1];
                c_be[k]    <= c_be[k-1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Data alignment: memory word appears at accept+1 and is delayed
    // READ_LATENCY-1 further cycles to line up with the control pipeline.
    // ---------------------------------------------------------------------
    if (L == 1) begin : g_lat1
        assign aligned = mem_rdata;
    end else begin : g_latn
        logic [DATA_W-1:0] d_pipe [L-1];

        // NOTE: data stages are not reset; stale words never escape because the reset control pipeline qualifies them.
        always_ff @(posedge clk) begin
            d_pipe[0] <= mem_rdata;
            for (int k = 1; k < L - 1; k++) d_pipe[k] <= d_pipe[k-1];
        end

        assign aligned = d_pipe[L-2];
    end

    // ---------------------------------------------------------------------
    // Response
    // ---------------------------------------------------------------------
    assign rdv = c_valid[L-1];

    always_comb begin
        out_word = '0;
        if (!c_oor[L-1]) begin
            for (int i = 0; i < BE_W; i++) begin
                if (c_be[L-1][i]) out_word[8*i +: 8] = aligned[8*i +: 8];
            end
        end
    end

    // readdata holds the last returned word between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q      <= '0;
            reads_served <= 16'd0;
        end else if (rdv) begin
            rdata_q      <= out_word;
            reads_served <= reads_served + 16'd1;
        end
    end

    assign flsh.flsh_readdatavalid = rdv;
    assign flsh.flsh_readdata      = rdv ? out_word : rdata_q;
    assign range_err               = rdv && c_oor[L-1];

endmodule

// File: tb/tb_flash_read_responder.sv
// ---------------------------------------------------------------------------
// tb_flash_read_responder
//   Three responder instances with different timing parameters:
//     0: WAIT=2 LAT=3 MAX_PENDING=4   (basic reads, masking, range, restart)
//     1: WAIT=0 LAT=8 MAX_PENDING=2   (pending cap, retire/accept overlap)
//     2: WAIT=0 LAT=8 MAX_PENDING=4   (reset with reads in flight)
//   Stimulus pushes the expected response on accept; a per-instance monitor
//   pops and compares whenever readdatavalid is seen.
//   Inputs change on the falling edge; outputs are sampled 2 ns later.
// ---------------------------------------------------------------------------
module tb_flash_read_responder;
    localparam int N = 3;
    localparam int WAIT_P [N] = '{2, 0, 0};
    localparam int LAT_P  [N] = '{3, 8, 8};
    localparam int MAXP_P [N] = '{4, 2, 4};

    typedef struct packed {
        logic [31:0] data;
        logic        oor;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [22:0] t_addr   [N];
    logic        t_read   [N];
    logic [3:0]  t_be     [N];
    logic        t_wait   [N];
    logic        t_rdv    [N];
    logic [31:0] t_rdata  [N];
    logic        t_rerr   [N];
    logic        t_mrd    [N];
    logic [22:0] t_maddr  [N];
    logic [15:0] t_served [N];

    exp_t exp_q [N][$];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(logic [22:0] a);
        if (a == 23'd5) return 32'hDEADBEEF;
        if (a == 23'd6) return 32'h11223344;
        return {9'd0, a} ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        flash_read_if #(.ADDR_W(23), .DATA_W(32)) bus ();
        logic [31:0] mem_rdata;

        assign bus.flsh_address    = t_addr[g];
        assign bus.flsh_read       = t_read[g];
        assign bus.flsh_byteenable = t_be[g];
        assign t_wait[g]           = bus.flsh_waitrequest;
        assign t_rdv[g]            = bus.flsh_readdatavalid;
        assign t_rdata[g]          = bus.flsh_readdata;

        flash_read_responder #(
            .ADDR_W       (23),
            .DATA_W       (32),
            .MAX_ADDRESS  (23'h7FFFF),
            .WAIT_CYCLES  (WAIT_P[g]),
            .READ_LATENCY (LAT_P[g]),
            .MAX_PENDING  (MAXP_P[g])
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flsh         (bus),
            .mem_address  (t_maddr[g]),
            .mem_read     (t_mrd[g]),
            .mem_rdata    (mem_rdata),
            .range_err    (t_rerr[g]),
            .reads_served (t_served[g])
        );

        // Synchronous 1-cycle backing memory.
        always @(posedge clk) begin
            if (t_mrd[g]) mem_rdata <= mem_word(t_maddr[g]);
        end

        // Response monitor.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                #2;
                if (t_rdv[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("d%0d_unexpected_rdv", g), 32'(t_rdv[g]), 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("d%0d_rdata", g), t_rdata[g], e.data);
                        check($sformatf("d%0d_range_err", g), 32'(t_rerr[g]), 32'(e.oor));
                        check($sformatf("d%0d_rdv_cycle", g), 32'(cyc), 32'(e.due));
                    end
                end
            end
        end
    end

    // Issue one read on instance d starting at a falling edge; returns at the
    // falling edge after the accept with read still asserted.
    task automatic do_read(input int d, input logic [22:0] a, input logic [3:0] be,
                           input int exp_stalls, input logic [31:0] exp_data,
                           input bit exp_oor, input bit track);
        int   stalls   = 0;
        bit   accepted = 1'b0;
        exp_t e;
        t_addr[d] = a;
        t_be[d]   = be;
        t_read[d] = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            #2;
            if (!t_wait[d]) begin
                accepted = 1'b1;
                check($sformatf("d%0d_acc_mem_read", d), 32'(t_mrd[d]), 32'(!exp_oor));
                if (!exp_oor) check($sformatf("d%0d_acc_mem_addr", d), 32'(t_maddr[d]), 32'(a));
                if (track) begin
                    e.data = exp_data;
                    e.oor  = exp_oor;
                    e.due  = cyc + LAT_P[d];
                    exp_q[d].push_back(e);
                end
            end else begin
                stalls++;
                check($sformatf("d%0d_stall_mem_read", d), 32'(t_mrd[d]), 32'd0);
            end
            @(negedge clk);
        end
        check($sformatf("d%0d_accept_seen", d), 32'(accepted), 32'd1);
        check($sformatf("d%0d_stall_cycles", d), 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic idle(input int d, input int n);
        t_read[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish by 20000 ns, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < N; d++) begin
            t_addr[d] = '0;
            t_read[d] = 1'b0;
            t_be[d]   = 4'hF;
        end
        // Instance 1 has no stall cycles: a held read must still see waitrequest in reset.
        t_read[1] = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        for (int d = 0; d < N; d++) begin
            check($sformatf("d%0d_rst_wait", d), 32'(t_wait[d]), 32'd1);
            check($sformatf("d%0d_rst_rdv", d), 32'(t_rdv[d]), 32'd0);
            check($sformatf("d%0d_rst_rdata", d), t_rdata[d], 32'd0);
            check($sformatf("d%0d_rst_range_err", d), 32'(t_rerr[d]), 32'd0);
            check($sformatf("d%0d_rst_served", d), 32'(t_served[d]), 32'd0);
            check($sformatf("d%0d_rst_mem_read", d), 32'(t_mrd[d]), 32'd0);
        end
        t_read[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Instance 0: basic read, byte masking, back-to-back with range boundary.
        do_read(0, 23'd5, 4'hF, 2, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(0, 1);
        do_read(0, 23'd6, 4'b0101, 2, 32'h00220044, 1'b0, 1'b1);
        do_read(0, 23'h80000, 4'hF, 2, 32'h00000000, 1'b1, 1'b1);
        do_read(0, 23'h7FFFF, 4'hF, 2, 32'hC0D9FFFF, 1'b0, 1'b1);
        idle(0, 1);
        // Read withdrawn after one stall cycle: next request restarts the count.
        t_addr[0] = 23'd8;
        t_read[0] = 1'b1;
        #2;
        check("d0_abort_wait", 32'(t_wait[0]), 32'd1);
        @(negedge clk);
        t_read[0] = 1'b0;
        @(negedge clk);
        do_read(0, 23'd8, 4'hF, 2, 32'hC0DE0008, 1'b0, 1'b1);
        idle(0, 6);
        check("d0_served", 32'(t_served[0]), 32'd5);

        // Instance 1: cap of 2, third read waits for the first return at t8.
        do_read(1, 23'h10, 4'hF, 0, 32'hC0DE0010, 1'b0, 1'b1);
        do_read(1, 23'h11, 4'hF, 0, 32'hC0DE0011, 1'b0, 1'b1);
        do_read(1, 23'h12, 4'hF, 6, 32'hC0DE0012, 1'b0, 1'b1);
        do_read(1, 23'h13, 4'hF, 0, 32'hC0DE0013, 1'b0, 1'b1);
        #2;
        check("d1_cap_wait", 32'(t_wait[1]), 32'd1);
        idle(1, 10);
        check("d1_served", 32'(t_served[1]), 32'd4);

        // Instance 2: reset with three reads in flight.
        do_read(2, 23'h20, 4'hF, 0, 32'd0, 1'b0, 1'b0);
        do_read(2, 23'h21, 4'hF, 0, 32'd0, 1'b0, 1'b0);
        do_read(2, 23'h22, 4'hF, 0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("d2_inrst_wait", 32'(t_wait[2]), 32'd1);
        check("d2_inrst_rdv", 32'(t_rdv[2]), 32'd0);
        check("d0_inrst_rdata", t_rdata[0], 32'd0);
        check("d0_inrst_served", 32'(t_served[0]), 32'd0);
        @(negedge clk);
        t_read[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("d2_post_rst_served", 32'(t_served[2]), 32'd0);
        // Pending restarted at 0: four immediate accepts, the fifth waits for a return.
        do_read(2, 23'h30, 4'hF, 0, 32'hC0DE0030, 1'b0, 1'b1);
        do_read(2, 23'h31, 4'b1100, 0, 32'hC0DE0000, 1'b0, 1'b1);
        do_read(2, 23'h32, 4'b1001, 0, 32'hC0000032, 1'b0, 1'b1);
        do_read(2, 23'h33, 4'hF, 0, 32'hC0DE0033, 1'b0, 1'b1);
        do_read(2, 23'h34, 4'hF, 4, 32'hC0DE0034, 1'b0, 1'b1);
        idle(2, 12);
        check("d2_served", 32'(t_served[2]), 32'd5);

        for (int d = 0; d < N; d++) begin
            check($sformatf("d%0d_drained", d), 32'(exp_q[d].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
